// File: rtl/control_carro_pkg.sv
// rtl/control_carro_pkg.sv - shared screen geometry, lane count and FSM encodings for the car sequencer
package control_carro_pkg;

  localparam int ALTO_PANTALLA  = 480;
  localparam int ANCHO_PANTALLA = 640;
  localparam int NUM_CARRILES   = 4;

  localparam int POS_X_W   = $clog2(ANCHO_PANTALLA);
  localparam int POS_Y_W   = $clog2(ALTO_PANTALLA);
  localparam int CARRIL_W  = $clog2(NUM_CARRILES);
  localparam int PUNTAJE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CARGA  = 3'd1,
    ST_CORRE  = 3'd2,
    ST_CHOQUE = 3'd3,
    ST_FIN    = 3'd4
  } estado_e;

  function automatic logic [POS_X_W-1:0] carril_a_x(input logic [CARRIL_W-1:0] carril,
                                                    input int x0,
                                                    input int ancho);
    return POS_X_W'(x0 + int'(carril) * ancho);
  endfunction

endpackage

// File: rtl/control_carro_if.sv
// rtl/control_carro_if.sv - game-side inputs and CarroX-side strobes/coordinates of the car sequencer
interface control_carro_if;
  import control_carro_pkg::*;

  logic                 iStart;
  logic                 iColision;
  logic                 iFinCarro;
  logic                 oEnable;
  logic                 oSuma;
  logic                 oSalto;
  logic [POS_X_W-1:0]   oPosicionX;
  logic [POS_Y_W-1:0]   oPosicionY;
  logic [POS_X_W-1:0]   oPosicionAuxX;
  logic [POS_Y_W-1:0]   oPosicionAuxY;
  logic [PUNTAJE_W-1:0] oPuntaje;
  logic                 oJuegoActivo;
  logic                 oFinJuego;

  modport master (
    input  iStart, iColision, iFinCarro,
    output oEnable, oSuma, oSalto, oPosicionX, oPosicionY, oPosicionAuxX, oPosicionAuxY,
           oPuntaje, oJuegoActivo, oFinJuego
  );

  modport slave (
    output iStart, iColision, iFinCarro,
    input  oEnable, oSuma, oSalto, oPosicionX, oPosicionY, oPosicionAuxX, oPosicionAuxY,
           oPuntaje, oJuegoActivo, oFinJuego
  );

endinterface

// File: rtl/generador_carril.sv
// rtl/generador_carril.sv - free-running 8-bit LFSR whose low bits select the spawn lane X
module generador_carril
  import control_carro_pkg::*;
#(
  parameter int         CARRIL_X0    = 40,
  parameter int         CARRIL_ANCHO = 160,
  parameter logic [7:0] LFSR_SEMILLA = 8'hA5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic [POS_X_W-1:0] x_o
);

  logic [7:0]          lfsr_q;
  logic [7:0]          lfsr_d;
  logic [CARRIL_W-1:0] carril;

  // Fibonacci, taps 8,6,5,4: maximal length, so a non-zero seed never reaches 0
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEMILLA;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign carril = lfsr_q[CARRIL_W-1:0];
  assign x_o    = carril_a_x(carril, CARRIL_X0, CARRIL_ANCHO);

endmodule

// File: rtl/control_carro.sv
// rtl/control_carro.sv - spawn/step/park sequencer for the CarroX car register with score and level speed-up
module control_carro
  import control_carro_pkg::*;
#(
  parameter int         DIV_INICIAL  = 100000,
  parameter int         DIV_MIN      = 20000,
  parameter int         DIV_PASO     = 5000,
  parameter int         DIV_W        = 17,
  parameter int         PUNTOS_NIVEL = 5,
  parameter int         CARRIL_X0    = 40,
  parameter int         CARRIL_ANCHO = 160,
  parameter int         PARK_X       = 700,
  parameter int         PARK_Y       = 0,
  parameter logic [7:0] LFSR_SEMILLA = 8'hA5
) (
  input  logic           iClk,
  input  logic           iReset_n,
  control_carro_if.master bus
);

  localparam logic [DIV_W-1:0]     DivIni    = DIV_W'(DIV_INICIAL);
  localparam logic [DIV_W-1:0]     DivMin    = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0]     DivPaso   = DIV_W'(DIV_PASO);
  localparam logic [DIV_W-1:0]     DivUmbral = DIV_W'(DIV_MIN + DIV_PASO);
  localparam logic [PUNTAJE_W-1:0] NivelMax  = PUNTAJE_W'(PUNTOS_NIVEL - 1);
  localparam logic [PUNTAJE_W-1:0] PuntajeMax = '1;

  estado_e              estado_q, estado_d;
  logic [DIV_W-1:0]     tick_q, tick_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [PUNTAJE_W-1:0] puntaje_q, puntaje_d;
  logic [PUNTAJE_W-1:0] nivel_q, nivel_d;
  logic [POS_X_W-1:0]   pos_x_q, pos_x_d;
  logic                 enable_q, enable_d;
  logic                 suma_q, suma_d;
  logic                 salto_q, salto_d;
  logic                 activo_q, activo_d;
  logic                 fin_q, fin_d;
  logic [POS_X_W-1:0]   carril_x;

  generador_carril #(
    .CARRIL_X0   (CARRIL_X0),
    .CARRIL_ANCHO(CARRIL_ANCHO),
    .LFSR_SEMILLA(LFSR_SEMILLA)
  ) u_generador_carril (
    .clk_i (iClk),
    .rst_ni(iReset_n),
    .x_o   (carril_x)
  );

  always_comb begin
    estado_d  = estado_q;
    tick_d    = tick_q;
    div_d     = div_q;
    puntaje_d = puntaje_q;
    nivel_d   = nivel_q;
    pos_x_d   = pos_x_q;
    suma_d    = 1'b0;

    case (estado_q)
      ST_IDLE: begin
        if (bus.iStart) estado_d = ST_CARGA;
      end
      ST_CARGA: begin
        estado_d = ST_CORRE;
        tick_d   = '0;
      end
      ST_CORRE: begin
        if (bus.iColision) begin
          estado_d = ST_CHOQUE;
          tick_d   = '0;
        end else if (bus.iFinCarro) begin
          estado_d = ST_CARGA;
          tick_d   = '0;
          // nivel_q tracks score mod PUNTOS_NIVEL; a saturated score no longer levels up
          if (puntaje_q != PuntajeMax) begin
            puntaje_d = puntaje_q + 1'b1;
            if (nivel_q == NivelMax) begin
              nivel_d = '0;
              div_d   = (div_q < DivUmbral) ? DivMin : div_q - DivPaso;
            end else begin
              nivel_d = nivel_q + 1'b1;
            end
          end
        end else if (tick_q == div_q - 1'b1) begin
          tick_d = '0;
          suma_d = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_CHOQUE: begin
        estado_d = ST_FIN;
      end
      ST_FIN: begin
        if (bus.iStart) begin
          estado_d  = ST_CARGA;
          puntaje_d = '0;
          nivel_d   = '0;
          div_d     = DivIni;
        end
      end
      default: begin
        estado_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so each strobe lines up with its state
    if (estado_d == ST_CARGA) pos_x_d = carril_x;
    enable_d = (estado_d == ST_CARGA);
    salto_d  = (estado_d == ST_CHOQUE);
    activo_d = (estado_d == ST_CARGA) || (estado_d == ST_CORRE);
    fin_d    = (estado_d == ST_FIN);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      estado_q  <= ST_IDLE;
      tick_q    <= '0;
      div_q     <= DivIni;
      puntaje_q <= '0;
      nivel_q   <= '0;
      pos_x_q   <= '0;
      enable_q  <= 1'b0;
      suma_q    <= 1'b0;
      salto_q   <= 1'b0;
      activo_q  <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
      puntaje_q <= puntaje_d;
      nivel_q   <= nivel_d;
      pos_x_q   <= pos_x_d;
      enable_q  <= enable_d;
      suma_q    <= suma_d;
      salto_q   <= salto_d;
      activo_q  <= activo_d;
      fin_q     <= fin_d;
    end
  end

  assign bus.oEnable       = enable_q;
  assign bus.oSuma         = suma_q;
  assign bus.oSalto        = salto_q;
  assign bus.oPosicionX    = pos_x_q;
  assign bus.oPosicionY    = '0;
  assign bus.oPosicionAuxX = POS_X_W'(PARK_X);
  assign bus.oPosicionAuxY = POS_Y_W'(PARK_Y);
  assign bus.oPuntaje      = puntaje_q;
  assign bus.oJuegoActivo  = activo_q;
  assign bus.oFinJuego     = fin_q;

endmodule

// File: tb/tb_control_carro.sv
// tb/tb_control_carro.sv - directed self-checking bench for control_carro
module tb_control_carro;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_carro_if bus();

  control_carro #(
    .DIV_INICIAL (4),
    .DIV_MIN     (2),
    .DIV_PASO    (1),
    .PUNTOS_NIVEL(2)
  ) dut (
    .iClk    (clk),
    .iReset_n(rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference lane generator: x^8+x^6+x^5+x^4 LFSR, lane taken from the value before the CARGA edge
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  function automatic logic [31:0] x_esperado();
    return 40 + 160 * m_prev[1:0];
  endfunction

  logic       mon_en = 1'b0;
  logic [2:0] prev_str = 3'b000;
  always @(negedge clk) begin : monitor_strobes
    logic [2:0] s;
    if (mon_en) begin
      s = {bus.oEnable, bus.oSuma, bus.oSalto};
      check_eq("strobe_exclusivo", 32'(($countones(s) <= 1) && ((s & prev_str) == 3'b000)), 1);
      prev_str = s;
    end
  end

  task automatic esperar_suma(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.oSuma && n < 40);
    check_eq("suma_visto", bus.oSuma, 1);
  endtask

  task automatic medir_periodo(output int p);
    int d;
    esperar_suma(d);
    esperar_suma(p);
  endtask

  task automatic anotar(input int p);
    bus.iFinCarro = 1'b1;
    @(negedge clk);
    bus.iFinCarro = 1'b0;
    check_eq($sformatf("puntaje_%0d", p), bus.oPuntaje, p);
    check_eq("anotar_enable", bus.oEnable, 1);
    check_eq("anotar_suma", bus.oSuma, 0);
    check_eq("anotar_pos_x", bus.oPosicionX, x_esperado());
  endtask

  int per_tab [8] = '{4, 3, 3, 2, 2, 2, 2, 2};

  initial begin
    int n;
    bus.iStart    = 1'b0;
    bus.iColision = 1'b0;
    bus.iFinCarro = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_puntaje", bus.oPuntaje, 0);
    check_eq("rst_aux_x", bus.oPosicionAuxX, 700);
    check_eq("rst_aux_y", bus.oPosicionAuxY, 0);
    check_eq("rst_pos_x", bus.oPosicionX, 0);
    check_eq("rst_strobes", {bus.oEnable, bus.oSuma, bus.oSalto}, 0);
    check_eq("rst_activo", bus.oJuegoActivo, 0);
    check_eq("rst_fin", bus.oFinJuego, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    bus.iColision = 1'b1;
    @(negedge clk);
    bus.iColision = 1'b0;
    check_eq("idle_col_activo", bus.oJuegoActivo, 0);
    check_eq("idle_col_strobes", {bus.oEnable, bus.oSuma, bus.oSalto}, 0);
    @(negedge clk);
    check_eq("idle_col_fin", bus.oFinJuego, 0);

    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    check_eq("carga_enable", bus.oEnable, 1);
    check_eq("carga_pos_y", bus.oPosicionY, 0);
    check_eq("carga_pos_x", bus.oPosicionX, x_esperado());
    check_eq("carga_activo", bus.oJuegoActivo, 1);
    esperar_suma(n);
    check_eq("suma_latencia", n, 5);
    esperar_suma(n);
    check_eq("periodo_inicial", n, 4);

    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    check_eq("corre_start_enable", bus.oEnable, 0);
    check_eq("corre_start_activo", bus.oJuegoActivo, 1);

    for (int p = 1; p <= 8; p++) begin
      anotar(p);
      medir_periodo(n);
      check_eq($sformatf("periodo_p%0d", p), n, per_tab[p-1]);
    end

    bus.iColision = 1'b1;
    bus.iFinCarro = 1'b1;
    @(negedge clk);
    bus.iColision = 1'b0;
    bus.iFinCarro = 1'b0;
    check_eq("choque_salto", bus.oSalto, 1);
    check_eq("choque_puntaje", bus.oPuntaje, 8);
    check_eq("choque_enable", bus.oEnable, 0);
    check_eq("choque_activo", bus.oJuegoActivo, 0);
    @(negedge clk);
    check_eq("fin_salto", bus.oSalto, 0);
    check_eq("fin_flag", bus.oFinJuego, 1);
    bus.iColision = 1'b1;
    @(negedge clk);
    bus.iColision = 1'b0;
    check_eq("fin_col_flag", bus.oFinJuego, 1);
    check_eq("fin_col_strobes", {bus.oEnable, bus.oSuma, bus.oSalto}, 0);

    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    check_eq("reinicio_enable", bus.oEnable, 1);
    check_eq("reinicio_puntaje", bus.oPuntaje, 0);
    check_eq("reinicio_fin", bus.oFinJuego, 0);
    check_eq("reinicio_pos_x", bus.oPosicionX, x_esperado());
    medir_periodo(n);
    check_eq("periodo_reinicio", n, 4);

    anotar(1);
    esperar_suma(n);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_suma", bus.oSuma, 0);
    check_eq("rst_async_puntaje", bus.oPuntaje, 0);
    check_eq("rst_async_aux_x", bus.oPosicionAuxX, 700);
    check_eq("rst_async_aux_y", bus.oPosicionAuxY, 0);
    check_eq("rst_async_activo", bus.oJuegoActivo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_strobes", {bus.oEnable, bus.oSuma, bus.oSalto}, 0);
    check_eq("post_rst_activo", bus.oJuegoActivo, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
